// File: rtl/nuc_pkg.sv
// nuc_pkg: shared NUC coefficient definitions.
//   NUC_GAIN_W / NUC_OFST_W : width of one gain / offset coefficient
//   gain_pair_t / ofst_pair_t: {odd, even} coefficient pairs for one pixel pair
//   GAIN_ONE_DEF / OFST_ZERO_DEF: default unity-gain and zero-offset codes
//   gain_pair_fill / ofst_pair_fill: replicate one code into both halves of a pair
package nuc_pkg;

  localparam int NUC_GAIN_W = 16;
  localparam int NUC_OFST_W = 16;

  typedef struct packed {
    logic [NUC_GAIN_W-1:0] odd;
    logic [NUC_GAIN_W-1:0] even;
  } gain_pair_t;

  typedef struct packed {
    logic [NUC_OFST_W-1:0] odd;
    logic [NUC_OFST_W-1:0] even;
  } ofst_pair_t;

  localparam logic [NUC_GAIN_W-1:0] GAIN_ONE_DEF  = 16'h4000;
  localparam logic [NUC_OFST_W-1:0] OFST_ZERO_DEF = 16'h0000;

  function automatic gain_pair_t gain_pair_fill(input logic [NUC_GAIN_W-1:0] code);
    gain_pair_t pair;
    pair.odd  = code;
    pair.even = code;
    return pair;
  endfunction

  function automatic ofst_pair_t ofst_pair_fill(input logic [NUC_OFST_W-1:0] code);
    ofst_pair_t pair;
    pair.odd  = code;
    pair.even = code;
    return pair;
  endfunction

endpackage

// File: rtl/axis_nuc_coef_split_if.sv
// axis_nuc_coef_split_if: AXI4-Stream bundle used on the coefficient splitter.
//   tdata  [DATA_W-1:0]  payload
//   tvalid               source has data
//   tready               sink accepts data
//   tlast                end marker (frame end on input, line end on outputs)
// modport master drives tdata/tvalid/tlast, modport slave drives tready.
interface axis_nuc_coef_split_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_nuc_coef_fifo2.sv
// axis_nuc_coef_fifo2: 2-entry {tlast, tdata} FIFO driving one AXI4-Stream output.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data/push_last this cycle (caller guarantees not full)
//   push_data  : payload written on push
//   push_last  : tlast stored alongside the payload
//   room       : registered flag, FIFO holds at most one entry
//   m_axis     : output stream; head entry always sits in slot0_r so outputs are registers
module axis_nuc_coef_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              room,
  axis_nuc_coef_split_if.master m_axis
);

  logic [DATA_W:0] slot0_r;
  logic [DATA_W:0] slot1_r;
  logic [1:0]      count_r;
  logic [1:0]      count_nxt_s;
  logic            valid_r;
  logic            room_r;
  logic            pop_s;
  logic [DATA_W:0] wr_s;

  assign pop_s = m_axis.tready & valid_r;
  assign wr_s  = {push_last, push_data};

  // Next occupancy from push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
      valid_r <= 1'b0;
      room_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != 2'd0);
      room_r  <= (count_nxt_s <= 2'd1);
      case ({push, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= wr_s;
          end else begin
            slot1_r <= wr_s;
          end
        end
        2'b01: begin
          // Clear the head when the FIFO runs empty so idle outputs read as zero.
          if (count_r == 2'd1) begin
            slot0_r <= '0;
          end else begin
            slot0_r <= slot1_r;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            slot0_r <= slot1_r;
            slot1_r <= wr_s;
          end else begin
            slot0_r <= wr_s;
          end
        end
        default: begin
          slot0_r <= slot0_r;
        end
      endcase
    end
  end

  assign room          = room_r;
  assign m_axis.tvalid = valid_r;
  assign m_axis.tdata  = slot0_r[DATA_W-1:0];
  assign m_axis.tlast  = slot0_r[DATA_W];

endmodule

// File: rtl/axis_nuc_coef_split.sv
// axis_nuc_coef_split: splits the 64-bit {ofst_pair, gain_pair} coefficient stream into
// separate gain and offset AXI4-Streams with line-end tlast and frame tracking.
//   axis_aclk, axis_areset : clock, synchronous active-high reset
//   s_axis_coef  (slave)   : 64-bit input, [31:0] gain {odd,even}, [63:32] offset {odd,even}
//   m_axis_gain  (master)  : 32-bit gain pairs, tlast = end of line
//   m_axis_ofst  (master)  : 32-bit offset pairs, tlast = end of line
//   frame_done             : 1-cycle pulse after the last beat of a frame is accepted
//   sync_err               : sticky, DMA tlast disagreed with the line/row counters
//   err_clr                : clears sync_err (a simultaneous new error wins)
//   unity                  : present only with NUC_COEF_UNITY_EN; emit constant coefficients
// Build macro NUC_COEF_UNITY_EN adds the unity-coefficient mode; without it this is a pure splitter.
module axis_nuc_coef_split
  import nuc_pkg::*;
#(
  parameter int                    FRAME_WIDTH  = 640,
  parameter int                    FRAME_HEIGHT = 480,
  parameter logic [NUC_GAIN_W-1:0] GAIN_ONE     = GAIN_ONE_DEF,
  parameter logic [NUC_OFST_W-1:0] OFST_ZERO    = OFST_ZERO_DEF
) (
  input  logic axis_aclk,
  input  logic axis_areset,
  axis_nuc_coef_split_if.slave  s_axis_coef,
  axis_nuc_coef_split_if.master m_axis_gain,
  axis_nuc_coef_split_if.master m_axis_ofst,
  output logic frame_done,
  output logic sync_err,
  input  logic err_clr
`ifdef NUC_COEF_UNITY_EN
  ,
  input  logic unity
`endif
);

  localparam int COLS  = FRAME_WIDTH / 2;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic             frame_done_r;
  logic             sync_err_r;
  logic             gain_room_s;
  logic             ofst_room_s;
  logic             room_s;
  logic             acc_s;
  logic             gen_s;
  logic             push_s;
  logic             col_end_s;
  logic             frame_end_s;
  logic             in_last_s;
  logic             err_set_s;
  logic             unity_mode_s;
  gain_pair_t       gain_wr_s;
  ofst_pair_t       ofst_wr_s;

  assign room_s             = gain_room_s & ofst_room_s;
  // Ready comes only from registered state, never from tvalid.
  assign s_axis_coef.tready = room_s & ~unity_mode_s;
  assign acc_s              = s_axis_coef.tvalid & s_axis_coef.tready;
  assign push_s             = acc_s | gen_s;

  assign col_end_s   = (col_r == COL_LAST);
  assign frame_end_s = col_end_s & (row_r == ROW_LAST);
  // Generated frames carry no DMA tlast, so treat them as always in sync.
  assign in_last_s   = unity_mode_s ? frame_end_s : s_axis_coef.tlast;

`ifdef NUC_COEF_UNITY_EN
  logic unity_r;
  logic boundary_s;
  logic idle_s;

  assign boundary_s   = (col_r == '0) & (row_r == '0);
  assign idle_s       = boundary_s & ~m_axis_gain.tvalid & ~m_axis_ofst.tvalid;
  assign unity_mode_s = unity_r;
  // At a frame boundary generation waits for the FIFOs to drain so the mode can be re-sampled.
  assign gen_s        = unity_r & room_s & (~boundary_s | (idle_s & unity));

  // Unity mode latch, updated only at an idle frame boundary.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      unity_r <= 1'b0;
    end else if (idle_s & ~acc_s) begin
      unity_r <= unity;
    end else begin
      unity_r <= unity_r;
    end
  end
`else
  assign unity_mode_s = 1'b0;
  assign gen_s        = 1'b0;
`endif

  // FIFO write data: DMA payload or the constant unity coefficients.
  always_comb begin
    gain_wr_s = s_axis_coef.tdata[31:0];
    ofst_wr_s = s_axis_coef.tdata[63:32];
    if (unity_mode_s) begin
      gain_wr_s = gain_pair_fill(GAIN_ONE);
      ofst_wr_s = ofst_pair_fill(OFST_ZERO);
    end else begin
      gain_wr_s = s_axis_coef.tdata[31:0];
      ofst_wr_s = s_axis_coef.tdata[63:32];
    end
  end

  // Error when DMA tlast and counter frame end disagree on an accepted beat.
  assign err_set_s = push_s & (frame_end_s ^ in_last_s);

  // Column/row counters, frame_done pulse and sticky sync error.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      col_r        <= '0;
      row_r        <= '0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      frame_done_r <= push_s & (frame_end_s | in_last_s);
      if (err_set_s) begin
        sync_err_r <= 1'b1;
      end else if (err_clr) begin
        sync_err_r <= 1'b0;
      end else begin
        sync_err_r <= sync_err_r;
      end
      if (push_s) begin
        // An early DMA tlast resynchronises the counters to the DMA frame.
        if (frame_end_s | in_last_s) begin
          col_r <= '0;
          row_r <= '0;
        end else if (col_end_s) begin
          col_r <= '0;
          row_r <= row_r + ROW_ONE;
        end else begin
          col_r <= col_r + COL_ONE;
        end
      end else begin
        col_r <= col_r;
      end
    end
  end

  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;

  axis_nuc_coef_fifo2 #(.DATA_W(32)) u_gain_fifo (
    .clk       (axis_aclk),
    .rst       (axis_areset),
    .push      (push_s),
    .push_data (gain_wr_s),
    .push_last (col_end_s),
    .room      (gain_room_s),
    .m_axis    (m_axis_gain)
  );

  axis_nuc_coef_fifo2 #(.DATA_W(32)) u_ofst_fifo (
    .clk       (axis_aclk),
    .rst       (axis_areset),
    .push      (push_s),
    .push_data (ofst_wr_s),
    .push_last (col_end_s),
    .room      (ofst_room_s),
    .m_axis    (m_axis_ofst)
  );

endmodule
